symbol_serializer: RTL

Parametrised word-to-symbol serializer for the input encoding path. Accepts WORD_W-bit words into a small FIFO and emits each word as WORD_W/SYM_W symbols of SYM_W bits, one `ready` strobe per symbol. Symbols are spaced by a programmable gap and throttled by the downstream `busy`. Each word can be sent MSB-first or LSB-first.

---
 rtl/symbol_serializer_if.sv | 37 +++
 rtl/symbol_serializer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/symbol_serializer_if.sv
// Handshake/data bundle for symbol_serializer; parity_out exists only when
// SYMBOL_PARITY_EN is defined.
interface symbol_serializer_if #(
   parameter int WORD_W = 8,
   parameter int SYM_W  = 4
);
   logic              active;
   logic              mode;
   logic              wr_en;
   logic [WORD_W-1:0] byte_in;
   logic              busy;
   logic [SYM_W-1:0]  bits_out;
   logic              ready;
   logic              done;
   logic              full;
   logic              empty;
   logic              overflow;
`ifdef SYMBOL_PARITY_EN
   logic              parity_out;
`endif

   modport master (
      output active, mode, wr_en, byte_in, busy,
`ifdef SYMBOL_PARITY_EN
      input  parity_out,
`endif
      input  bits_out, ready, done, full, empty, overflow
   );

   modport slave (
      input  active, mode, wr_en, byte_in, busy,
`ifdef SYMBOL_PARITY_EN
      output parity_out,
`endif
      output bits_out, ready, done, full, empty, overflow
   );
endinterface

// File: rtl/symbol_serializer.sv
// Word FIFO feeding a gap-spaced, busy-throttled symbol serializer.
// Optional even-parity output enabled by the SYMBOL_PARITY_EN macro.
module symbol_serializer #(
   parameter int WORD_W     = 8,
   parameter int SYM_W      = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int GAP        = 4
) (
   input  logic               clk,
   input  logic               reset,
   symbol_serializer_if.slave bus
);
   localparam int NSYM = WORD_W / SYM_W;
   localparam int SC_W = (NSYM > 1) ? $clog2(NSYM) : 1;
   localparam int GC_W = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CW   = AW + 1;
   localparam logic [SC_W-1:0] LAST_SYM = SC_W'(NSYM - 1);
   localparam logic [GC_W-1:0] GAP_LAST = GC_W'(GAP - 1);
   localparam logic [CW-1:0]   DEPTH_C  = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_EMIT, S_GAP} state_t;

   state_t            state_q, state_d;
   logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
   logic [WORD_W-1:0] mem_d [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              full_q, full_d, empty_q, empty_d;
   logic              overflow_q, overflow_d;
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic              mode_q, mode_d;
   logic [SC_W-1:0]   sym_cnt_q, sym_cnt_d;
   logic              last_q, last_d;
   logic [GC_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic [SYM_W-1:0]  bits_q, bits_d;
   logic              ready_q, ready_d, done_q, done_d;
   logic              push, pop;
   logic [SYM_W-1:0]  sym;

   assign sym = mode_q ? shreg_q[SYM_W-1:0] : shreg_q[WORD_W-1 -: SYM_W];

   always_comb begin
      state_d    = state_q;
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      shreg_d    = shreg_q;
      mode_d     = mode_q;
      sym_cnt_d  = sym_cnt_q;
      last_d     = last_q;
      gap_cnt_d  = gap_cnt_q;
      bits_d     = bits_q;
      ready_d    = 1'b0;
      done_d     = 1'b0;
      pop        = 1'b0;
      // full is the registered flag, so a write while full drops even if a pop happens now
      push       = bus.wr_en && !full_q;
      overflow_d = overflow_q || (bus.wr_en && full_q);

      case (state_q)
         S_IDLE: begin
            if (bus.active && !empty_q) begin
               pop     = 1'b1;
               state_d = S_EMIT;
            end
         end
         S_EMIT: begin
            bits_d    = sym;
            ready_d   = 1'b1;
            done_d    = (sym_cnt_q == LAST_SYM);
            last_d    = (sym_cnt_q == LAST_SYM);
            shreg_d   = mode_q ? (shreg_q >> SYM_W) : (shreg_q << SYM_W);
            sym_cnt_d = sym_cnt_q + SC_W'(1);
            gap_cnt_d = '0;
            state_d   = S_GAP;
         end
         S_GAP: begin
            if (gap_cnt_q != GAP_LAST) begin
               gap_cnt_d = gap_cnt_q + GC_W'(1);
            end else if (!bus.busy) begin
               if (!last_q) begin
                  state_d = S_EMIT;
               end else if (bus.active && !empty_q) begin
                  pop     = 1'b1;
                  state_d = S_EMIT;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (pop) begin
         shreg_d   = mem_q[rd_ptr_q];
         mode_d    = bus.mode;
         sym_cnt_d = '0;
         rd_ptr_d  = rd_ptr_q + AW'(1);
      end
      if (push) begin
         mem_d[wr_ptr_q] = bus.byte_in;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
      full_d  = (count_d == DEPTH_C);
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         mem_q      <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
         shreg_q    <= '0;
         mode_q     <= 1'b0;
         sym_cnt_q  <= '0;
         last_q     <= 1'b0;
         gap_cnt_q  <= '0;
         bits_q     <= '0;
         ready_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         overflow_q <= overflow_d;
         shreg_q    <= shreg_d;
         mode_q     <= mode_d;
         sym_cnt_q  <= sym_cnt_d;
         last_q     <= last_d;
         gap_cnt_q  <= gap_cnt_d;
         bits_q     <= bits_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
      end
   end

   assign bus.bits_out = bits_q;
   assign bus.ready    = ready_q;
   assign bus.done     = done_q;
   assign bus.full     = full_q;
   assign bus.empty    = empty_q;
   assign bus.overflow = overflow_q;

`ifdef SYMBOL_PARITY_EN
   logic parity_q, parity_d;

   always_comb begin
      parity_d = parity_q;
      if (state_q == S_EMIT) begin
         parity_d = ^sym;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end

   assign bus.parity_out = parity_q;
`endif
endmodule
